// File: rtl/ccc_apb_reconfig_master.sv
`default_nettype none
// ============================================================================
// Module      : ccc_apb_reconfig_master
// Description : APB initiator for the CCC dynamic-reconfiguration port, with
//               optional PLL reset pulse and LOCK re-acquisition per write.
// Revision    : 1.0 - initial release
// ============================================================================
module ccc_apb_reconfig_master #(
  parameter int unsigned ARST_CYCLES  = 16,
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned BUSY_TIMEOUT = 1023
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic       CMD_WRITE,
  input  logic       CMD_RELOCK,
  input  logic [5:0] CMD_ADDR,
  input  logic [7:0] CMD_WDATA,
  output logic       RSP_VALID,
  output logic [7:0] RSP_RDATA,
  output logic       RSP_ERR,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [5:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       BUSY,
  input  logic       LOCK,
  output logic       PLL_ARST_N,
  output logic       LOCK_OK
);

  localparam int unsigned c_CNT_MAX_A = (LOCK_TIMEOUT > BUSY_TIMEOUT) ? LOCK_TIMEOUT : BUSY_TIMEOUT;
  localparam int unsigned c_CNT_MAX   = (c_CNT_MAX_A > ARST_CYCLES) ? c_CNT_MAX_A : ARST_CYCLES;
  localparam int unsigned c_CNT_W     = $clog2(c_CNT_MAX + 1);

  localparam logic [c_CNT_W-1:0] c_BUSY_TO   = c_CNT_W'(BUSY_TIMEOUT);
  localparam logic [c_CNT_W-1:0] c_LOCK_TO   = c_CNT_W'(LOCK_TIMEOUT);
  localparam logic [c_CNT_W-1:0] c_ARST_LAST = c_CNT_W'(ARST_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

  localparam logic [2:0] c_IDLE      = 3'd0;
  localparam logic [2:0] c_WAIT_BUSY = 3'd1;
  localparam logic [2:0] c_SETUP     = 3'd2;
  localparam logic [2:0] c_ACCESS    = 3'd3;
  localparam logic [2:0] c_PLL_RST   = 3'd4;
  localparam logic [2:0] c_WAIT_LOCK = 3'd5;
  localparam logic [2:0] c_RSP       = 3'd6;

  logic [2:0]         state_q, state_d;
  logic [c_CNT_W-1:0] cnt_q;
  logic               write_q, relock_q, err_q;
  logic [5:0]         addr_q, paddr_q;
  logic [7:0]         wdata_q, pwdata_q, rdata_q;
  logic               sync1_q, sync2_q, lock_seen_q;

  logic w_accept, w_busy_to, w_lock_to, w_arst_done, w_lock_ok2;

  assign w_accept    = CMD_VALID && CMD_READY;
  assign w_busy_to   = (cnt_q >= c_BUSY_TO);
  assign w_lock_to   = (cnt_q >= c_LOCK_TO);
  assign w_arst_done = (cnt_q >= c_ARST_LAST);
  // lock_seen_q remembers LOCK_OK from the previous WAIT_LOCK cycle
  assign w_lock_ok2  = sync2_q && lock_seen_q;

  always_ff @(posedge PCLK) begin
    if (PRESET) state_q <= c_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:      if (w_accept) state_d = BUSY ? c_WAIT_BUSY : c_SETUP;
      c_WAIT_BUSY: begin
        if (!BUSY)          state_d = c_SETUP;
        else if (w_busy_to) state_d = c_RSP;
      end
      c_SETUP:     state_d = c_ACCESS;
      c_ACCESS:    state_d = relock_q ? c_PLL_RST : c_RSP;
      c_PLL_RST:   if (w_arst_done) state_d = c_WAIT_LOCK;
      c_WAIT_LOCK: if (w_lock_ok2 || w_lock_to) state_d = c_RSP;
      c_RSP:       state_d = c_IDLE;
      default:     state_d = c_IDLE;
    endcase
  end

  always_comb begin
    CMD_READY  = (state_q == c_IDLE) && !PRESET;
    PSEL       = (state_q == c_SETUP) || (state_q == c_ACCESS);
    PENABLE    = (state_q == c_ACCESS);
    PWRITE     = PSEL && write_q;
    PADDR      = paddr_q;
    PWDATA     = pwdata_q;
    PLL_ARST_N = (state_q != c_PLL_RST);
    RSP_VALID  = (state_q == c_RSP);
    RSP_RDATA  = RSP_VALID ? rdata_q : 8'h00;
    RSP_ERR    = RSP_VALID && err_q;
    LOCK_OK    = sync2_q;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      cnt_q       <= '0;
      write_q     <= 1'b0;
      relock_q    <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= 6'h00;
      paddr_q     <= 6'h00;
      wdata_q     <= 8'h00;
      pwdata_q    <= 8'h00;
      rdata_q     <= 8'h00;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      lock_seen_q <= 1'b0;
    end else begin
      cnt_q       <= (state_d != state_q) ? '0 : cnt_q + c_CNT_ONE;
      sync1_q     <= LOCK;
      sync2_q     <= sync1_q;
      lock_seen_q <= (state_q == c_WAIT_LOCK) && sync2_q;
      if (w_accept) begin
        write_q  <= CMD_WRITE;
        relock_q <= CMD_RELOCK && CMD_WRITE;
        addr_q   <= CMD_ADDR;
        wdata_q  <= CMD_WDATA;
        rdata_q  <= 8'h00;
        err_q    <= 1'b0;
      end
      // Direct IDLE->SETUP entry bypasses the command latch, loaded on the same edge
      if (state_d == c_SETUP) begin
        paddr_q  <= (state_q == c_IDLE) ? CMD_ADDR  : addr_q;
        pwdata_q <= (state_q == c_IDLE) ? CMD_WDATA : wdata_q;
      end
      if ((state_q == c_ACCESS) && !write_q) rdata_q <= PRDATA;
      if ((state_q == c_WAIT_BUSY) && BUSY && w_busy_to) err_q <= 1'b1;
      if ((state_q == c_WAIT_LOCK) && !w_lock_ok2 && w_lock_to) err_q <= 1'b1;
    end
  end

endmodule
`default_nettype wire
